fir_nibble_collector: RTL
=========================

// Module: fir_nibble_collector
// PURPOSE
//  Downstream stage of the FIR_PE systolic chain. Consumes the nibble-serial Y stream
//  (4-bit digit per Vld cycle, LSB nibble first) from the last PE and reassembles
//  full-width filter outputs. Buffers them in a small FIFO behind a valid/ready port.
//  Discards partial words after a stalled stream and flags FIFO overflow.
// PARAMETERS
//  N_NIB      4   nibbles per output word; word width W = 4*N_NIB
//  FIFO_DEPTH 4   output FIFO entries; power of 2, >= 2
//  GAP_MAX    15  max consecutive Vld-low cycles tolerated mid-word (1..255)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  Vld        in   1      nibble strobe from last FIR_PE
//  Yin        in   4      Y nibble, sampled when Vld=1
//  Dout       out  W      head-of-FIFO word
//  Dout_vld   out  1      FIFO not empty
//  Dout_rdy   in   1      consumer accepts Dout when Dout_vld & Dout_rdy
//  Level      out  clog2(FIFO_DEPTH)+1  FIFO occupancy
//  Drop       out  1      1-cycle pulse: partial word discarded on gap timeout
//  Ovf        out  1      sticky: completed word lost because FIFO full
//  Ovf_clr    in   1      synchronous clear of Ovf
// BEHAVIOUR
//  Reset: Dout=0, Dout_vld=0, Level=0, Drop=0, Ovf=0; FSM=IDLE; nib_cnt=0; gap_cnt=0.
//  FSM IDLE: waits for Vld. On Vld=1: store Yin at word[3:0], set nib_cnt=1,
//    go to COLLECT. If N_NIB==1, the word completes immediately.
//  FSM COLLECT: on Vld=1: store Yin at word[4*nib_cnt+:4], nib_cnt++, gap_cnt=0.
//    On Vld=0: gap_cnt++. When gap_cnt reaches GAP_MAX: discard the partial word,
//    pulse Drop for 1 cycle, go to IDLE.
//  Word completion: the edge that samples nibble N_NIB-1 pushes the assembled word
//    into the FIFO at that same edge, then returns to IDLE (nib_cnt=0).
//    A Vld on the next cycle starts a new word; back-to-back words need no gap.
//  Latency: with the FIFO empty, Dout/Dout_vld are valid in the cycle after the
//    edge that sampled the last nibble.
//  FIFO: first-word fall-through. Pop occurs on an edge with Dout_vld & Dout_rdy.
//    A push is accepted if Level<FIFO_DEPTH, or if a pop occurs on the same edge.
//    Simultaneous push+pop leaves Level unchanged.
//    Pointers wrap modulo FIFO_DEPTH. Dout holds its value while Dout_rdy=0.
//  Overflow: if a push is not accepted, the word is dropped, Ovf is set to 1 and
//    FIFO contents are unchanged. If Ovf_clr and a new overflow occur on the same
//    edge, set wins.
//  Yin is ignored when Vld=0. No arithmetic on data; nibbles are concatenated only.
//  Reset asserted mid-word or with the FIFO non-empty: all data is lost. No Drop
//    pulse and no Ovf are generated.
// TESTING
//  1 Vld 4 cycles with Yin=4,3,2,1 (N_NIB=4) -> Dout=16'h1234, Dout_vld=1 on the
//    next cycle.
//  2 Nibbles 4,3 then Vld low for 15 cycles -> Drop=1 for 1 cycle, no push.
//    Next nibbles 8,7,6,5 -> Dout=16'h5678.
//  3 Same as 2 with a 14-cycle gap -> no Drop; word 16'h1234 assembled across the gap.
//  4 Dout_rdy=0, push 5 words 0x0001..0x0005 -> Level=4, Ovf=1, Dout=0x0001.
//    Then Dout_rdy=1 -> pops 1,2,3,4; 5 never appears.
//  5 FIFO full with Dout_rdy=1 as word 0x00AA completes -> push+pop on the same edge,
//    Level stays 4, Ovf stays 0.
//  6 reset pulsed after 2 nibbles, with 2 words queued -> Level=0, Dout_vld=0.
//    Next 4 nibbles form a clean word.

Source files
------------

// File: rtl/fir_nibble_collector.sv
`default_nettype none
// ============================================================================
// Module      : fir_nibble_collector
// Description : Tail stage of the FIR_PE systolic chain. Gathers the
//               nibble-serial Y stream (LSB nibble first) into full-width
//               words and queues them in a first-word fall-through FIFO
//               behind a valid/ready port. Drops a stalled partial word
//               after GAP_MAX idle cycles and flags lost words on overflow.
// Ports       : clk       - clock, all state on rising edge
//               reset     - asynchronous active-high reset
//               Vld/Yin   - nibble strobe and 4-bit nibble from last PE
//               Dout      - head-of-FIFO word (0 when FIFO is empty)
//               Dout_vld  - FIFO not empty
//               Dout_rdy  - consumer accepts Dout when Dout_vld & Dout_rdy
//               Level     - FIFO occupancy
//               Drop      - one-cycle pulse when a partial word is discarded
//               Ovf       - sticky flag: completed word lost, FIFO full
//               Ovf_clr   - synchronous clear of Ovf
// Revision    : 1.0 - initial release
// ============================================================================
module fir_nibble_collector #(
    parameter int N_NIB      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MAX    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Vld,
    input  logic [3:0]                    Yin,
    output logic [4*N_NIB-1:0]            Dout,
    output logic                          Dout_vld,
    input  logic                          Dout_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          Drop,
    output logic                          Ovf,
    input  logic                          Ovf_clr
);

    localparam int c_WORD_W = 4 * N_NIB;
    localparam int c_NIB_W  = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = c_AW + 1;

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_COLLECT = 1'b1;

    // ------------------------------------------------------------------
    // Assembler state
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_NIB_W-1:0]  r_nib_cnt;
    logic [c_NIB_W-1:0]  w_nib_next;
    logic [7:0]          r_gap_cnt;
    logic [7:0]          w_gap_next;
    logic [c_WORD_W-1:0] r_word;
    logic [c_WORD_W-1:0] w_word_next;
    logic                w_push;
    logic                w_drop;
    logic                r_drop;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_ovf;
    logic                w_fifo_vld;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_ovf_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_nib_cnt <= '0;
            r_gap_cnt <= '0;
            r_word    <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_nib_cnt <= w_nib_next;
            r_gap_cnt <= w_gap_next;
            r_word    <= w_word_next;
            r_drop    <= w_drop;
        end
    end

    // The word pushed into the FIFO is w_word_next, i.e. the partial word
    // with the nibble sampled on this edge already merged in, so a word
    // completes on the same edge that samples its last nibble.
    always_comb begin
        w_state_next = r_state;
        w_nib_next   = r_nib_cnt;
        w_gap_next   = r_gap_cnt;
        w_word_next  = r_word;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (Vld) begin
                    w_word_next      = '0;
                    w_word_next[3:0] = Yin;
                    w_gap_next       = '0;
                    if (N_NIB == 1) begin
                        w_push = 1'b1;
                    end else begin
                        w_nib_next   = c_NIB_W'(1);
                        w_state_next = c_ST_COLLECT;
                    end
                end
            end
            c_ST_COLLECT: begin
                if (Vld) begin
                    for (int i = 0; i < N_NIB; i++) begin
                        if (r_nib_cnt == c_NIB_W'(i)) begin
                            w_word_next[4*i +: 4] = Yin;
                        end
                    end
                    w_gap_next = '0;
                    if (r_nib_cnt == c_NIB_W'(N_NIB - 1)) begin
                        w_push       = 1'b1;
                        w_nib_next   = '0;
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_nib_next = r_nib_cnt + c_NIB_W'(1);
                    end
                end else if (r_gap_cnt == 8'(GAP_MAX - 1)) begin
                    // This idle cycle is the GAP_MAX-th in a row: give up.
                    w_drop       = 1'b1;
                    w_nib_next   = '0;
                    w_gap_next   = '0;
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_nib_next   = '0;
                w_gap_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    assign w_fifo_vld = (r_level != '0);
    assign w_full     = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_pop      = w_fifo_vld & Dout_rdy;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_ovf_set  = w_push & ~w_push_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_word_next;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A new overflow outranks a clear on the same edge.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (Ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign Dout     = w_fifo_vld ? r_mem[r_rd_ptr] : '0;
    assign Dout_vld = w_fifo_vld;
    assign Level    = r_level;
    assign Drop     = r_drop;
    assign Ovf      = r_ovf;

endmodule
`default_nettype wire
